// File: rtl/axi_addr_xlate_pkg.sv
// Shared types for the registered AW/AR address translator.
// Also defines AXI_ADDR_XLATE_TYPEDEF_RULE_T for building rule structs.
// The optional miss counter is enabled with AXI_ADDR_XLATE_MISS_CNT_EN.

`define AXI_ADDR_XLATE_TYPEDEF_RULE_T(name, slv_addr_t, mst_addr_t) \
    typedef struct packed {                                         \
        logic      en;                                              \
        slv_addr_t start;                                           \
        slv_addr_t end_;                                            \
        mst_addr_t offset;                                          \
    } name;

package axi_addr_xlate_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } xlate_state_e;

    // Default channel beat, used when the parent does not override ax_chan_t
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } default_ax_chan_t;

    `AXI_ADDR_XLATE_TYPEDEF_RULE_T(default_rule_t, logic [31:0], logic [31:0])

endpackage

// File: rtl/axi_addr_xlate_chan.sv
// One translator channel: capture FSM, beat/address registers, rule lookup.
// With AXI_ADDR_XLATE_MISS_CNT_EN defined, also a saturating miss counter.

module axi_addr_xlate_chan
    import axi_addr_xlate_pkg::*;
#(
    parameter int unsigned NumRules     = 4,
    parameter int unsigned SlvAddrWidth = 32,
    parameter int unsigned MstAddrWidth = 32,
    parameter type         ax_chan_t    = default_ax_chan_t,
    parameter type         rule_t       = default_rule_t
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  rule_t [NumRules-1:0]      rules_i,
    input  ax_chan_t                  slv_i,
    input  logic                      slv_valid_i,
    output logic                      slv_ready_o,
    output ax_chan_t                  mst_o,
    output logic [MstAddrWidth-1:0]   mst_addr_o,
    output logic                      mst_miss_o,
    output logic                      mst_valid_o,
    input  logic                      mst_ready_i
`ifdef AXI_ADDR_XLATE_MISS_CNT_EN
    ,
    output logic [15:0]               miss_cnt_o
`endif
);

    localparam int unsigned AddrW = (SlvAddrWidth > MstAddrWidth) ? SlvAddrWidth : MstAddrWidth;

    xlate_state_e            state_q, state_d;
    logic                    capture;
    logic [SlvAddrWidth-1:0] slv_addr;
    logic [MstAddrWidth-1:0] lookup_addr;
    logic                    lookup_miss;
    ax_chan_t                beat_q;
    logic [MstAddrWidth-1:0] addr_q;
    logic                    miss_q;

    assign slv_addr = slv_i.addr;

    // Rule lookup on the incoming address; first enabled window hit wins
    always_comb begin
        lookup_addr = MstAddrWidth'(slv_addr);
        lookup_miss = 1'b1;
        for (int i = 0; i < int'(NumRules); i++) begin
            if (lookup_miss && rules_i[i].en &&
                (rules_i[i].start <= slv_addr) && (slv_addr < rules_i[i].end_)) begin
                lookup_miss = 1'b0;
                lookup_addr = MstAddrWidth'((AddrW'(slv_addr) - AddrW'(rules_i[i].start))
                                            + AddrW'(rules_i[i].offset));
            end
        end
    end

    // Channel state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs; ready/valid depend only on state
    always_comb begin
        state_d     = state_q;
        capture     = 1'b0;
        slv_ready_o = 1'b0;
        mst_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                slv_ready_o = 1'b1;
                if (slv_valid_i) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                mst_valid_o = 1'b1;
                if (mst_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Held beat, translated address and miss flag, loaded only on capture
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_q <= '0;
            addr_q <= '0;
            miss_q <= 1'b0;
        end else if (capture) begin
            beat_q <= slv_i;
            addr_q <= lookup_addr;
            miss_q <= lookup_miss;
        end
    end

    assign mst_o      = beat_q;
    assign mst_addr_o = addr_q;
    assign mst_miss_o = miss_q;

`ifdef AXI_ADDR_XLATE_MISS_CNT_EN
    logic [15:0] miss_cnt_q;

    // Count captured misses, saturating at all ones
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            miss_cnt_q <= '0;
        end else if (capture && lookup_miss && (miss_cnt_q != 16'hFFFF)) begin
            miss_cnt_q <= miss_cnt_q + 16'd1;
        end
    end

    assign miss_cnt_o = miss_cnt_q;
`else
    // No miss counter in this build
`endif

endmodule

// File: rtl/axi_addr_xlate.sv
// Registered AW/AR address translator: two independent channel instances
// sharing one rule table. Define AXI_ADDR_XLATE_MISS_CNT_EN to add
// per-channel 16-bit saturating miss counters.

module axi_addr_xlate
    import axi_addr_xlate_pkg::*;
#(
    parameter int unsigned NumRules     = 4,
    parameter int unsigned SlvAddrWidth = 32,
    parameter int unsigned MstAddrWidth = 32,
    parameter type         ax_chan_t    = default_ax_chan_t,
    parameter type         rule_t       = default_rule_t
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  rule_t [NumRules-1:0]      rules_i,
    input  ax_chan_t                  slv_aw_i,
    input  logic                      slv_aw_valid_i,
    output logic                      slv_aw_ready_o,
    output ax_chan_t                  mst_aw_o,
    output logic [MstAddrWidth-1:0]   mst_aw_addr_o,
    output logic                      mst_aw_miss_o,
    output logic                      mst_aw_valid_o,
    input  logic                      mst_aw_ready_i,
    input  ax_chan_t                  slv_ar_i,
    input  logic                      slv_ar_valid_i,
    output logic                      slv_ar_ready_o,
    output ax_chan_t                  mst_ar_o,
    output logic [MstAddrWidth-1:0]   mst_ar_addr_o,
    output logic                      mst_ar_miss_o,
    output logic                      mst_ar_valid_o,
    input  logic                      mst_ar_ready_i
`ifdef AXI_ADDR_XLATE_MISS_CNT_EN
    ,
    output logic [15:0]               aw_miss_cnt_o,
    output logic [15:0]               ar_miss_cnt_o
`endif
);

    axi_addr_xlate_chan #(
        .NumRules     (NumRules),
        .SlvAddrWidth (SlvAddrWidth),
        .MstAddrWidth (MstAddrWidth),
        .ax_chan_t    (ax_chan_t),
        .rule_t       (rule_t)
    ) u_aw_chan (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rules_i     (rules_i),
        .slv_i       (slv_aw_i),
        .slv_valid_i (slv_aw_valid_i),
        .slv_ready_o (slv_aw_ready_o),
        .mst_o       (mst_aw_o),
        .mst_addr_o  (mst_aw_addr_o),
        .mst_miss_o  (mst_aw_miss_o),
        .mst_valid_o (mst_aw_valid_o),
        .mst_ready_i (mst_aw_ready_i)
`ifdef AXI_ADDR_XLATE_MISS_CNT_EN
        ,
        .miss_cnt_o  (aw_miss_cnt_o)
`endif
    );

    axi_addr_xlate_chan #(
        .NumRules     (NumRules),
        .SlvAddrWidth (SlvAddrWidth),
        .MstAddrWidth (MstAddrWidth),
        .ax_chan_t    (ax_chan_t),
        .rule_t       (rule_t)
    ) u_ar_chan (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rules_i     (rules_i),
        .slv_i       (slv_ar_i),
        .slv_valid_i (slv_ar_valid_i),
        .slv_ready_o (slv_ar_ready_o),
        .mst_o       (mst_ar_o),
        .mst_addr_o  (mst_ar_addr_o),
        .mst_miss_o  (mst_ar_miss_o),
        .mst_valid_o (mst_ar_valid_o),
        .mst_ready_i (mst_ar_ready_i)
`ifdef AXI_ADDR_XLATE_MISS_CNT_EN
        ,
        .miss_cnt_o  (ar_miss_cnt_o)
`endif
    );

endmodule

// File: tb/tb_axi_addr_xlate.sv
// Directed testbench for axi_addr_xlate: a vector table of single beats plus
// hand-written multi-cycle sequences (stall, dual capture, reset in HOLD).

module tb_axi_addr_xlate;
    import axi_addr_xlate_pkg::*;

    localparam int NumRules = 4;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    default_rule_t [NumRules-1:0]  rules = '0;
    default_ax_chan_t              slv_aw = '0, slv_ar = '0;
    default_ax_chan_t              mst_aw, mst_ar;
    logic                          slv_aw_valid = 1'b0, slv_ar_valid = 1'b0;
    logic                          slv_aw_ready, slv_ar_ready;
    logic [31:0]                   mst_aw_addr, mst_ar_addr;
    logic                          mst_aw_miss, mst_ar_miss;
    logic                          mst_aw_valid, mst_ar_valid;
    logic                          mst_aw_ready = 1'b0, mst_ar_ready = 1'b0;
`ifdef AXI_ADDR_XLATE_MISS_CNT_EN
    logic [15:0]                   aw_miss_cnt, ar_miss_cnt;
    int                            exp_aw_cnt = 0, exp_ar_cnt = 0;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ar;
        logic [31:0] addr;
        logic [31:0] exp_addr;
        logic        exp_miss;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    axi_addr_xlate #(
        .NumRules     (NumRules),
        .SlvAddrWidth (32),
        .MstAddrWidth (32),
        .ax_chan_t    (default_ax_chan_t),
        .rule_t       (default_rule_t)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .rules_i        (rules),
        .slv_aw_i       (slv_aw),
        .slv_aw_valid_i (slv_aw_valid),
        .slv_aw_ready_o (slv_aw_ready),
        .mst_aw_o       (mst_aw),
        .mst_aw_addr_o  (mst_aw_addr),
        .mst_aw_miss_o  (mst_aw_miss),
        .mst_aw_valid_o (mst_aw_valid),
        .mst_aw_ready_i (mst_aw_ready),
        .slv_ar_i       (slv_ar),
        .slv_ar_valid_i (slv_ar_valid),
        .slv_ar_ready_o (slv_ar_ready),
        .mst_ar_o       (mst_ar),
        .mst_ar_addr_o  (mst_ar_addr),
        .mst_ar_miss_o  (mst_ar_miss),
        .mst_ar_valid_o (mst_ar_valid),
        .mst_ar_ready_i (mst_ar_ready)
`ifdef AXI_ADDR_XLATE_MISS_CNT_EN
        ,
        .aw_miss_cnt_o  (aw_miss_cnt),
        .ar_miss_cnt_o  (ar_miss_cnt)
`endif
    );

    function automatic default_rule_t mk_rule(input logic en, input logic [31:0] s,
                                              input logic [31:0] e, input logic [31:0] o);
        default_rule_t r;
        r.en     = en;
        r.start  = s;
        r.end_   = e;
        r.offset = o;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic setTableRules();
        rules[0] = mk_rule(1'b1, 32'h0000_1000, 32'h0000_2000, 32'h8000_0000);
        rules[1] = mk_rule(1'b1, 32'h0000_1800, 32'h0000_3000, 32'h4000_0000);
        rules[2] = mk_rule(1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001);
        rules[3] = mk_rule(1'b1, 32'h0000_5000, 32'h0000_5000, 32'h0000_0010);
    endtask

    // One beat through one channel: capture, check held outputs, complete, check idle
    task automatic applyStimulus(input int idx, input vec_t v);
        if (!v.ar) begin
            slv_aw.addr  = v.addr;
            slv_aw.id    = 4'(idx);
            slv_aw_valid = 1'b1;
        end else begin
            slv_ar.addr  = v.addr;
            slv_ar.id    = 4'(idx);
            slv_ar_valid = 1'b1;
        end
        tick();
        slv_aw_valid = 1'b0;
        slv_ar_valid = 1'b0;
        if (!v.ar) begin
            checkOutput($sformatf("v%0d_aw_valid", idx), 64'(mst_aw_valid), 64'd1);
            checkOutput($sformatf("v%0d_aw_addr", idx), 64'(mst_aw_addr), 64'(v.exp_addr));
            checkOutput($sformatf("v%0d_aw_miss", idx), 64'(mst_aw_miss), 64'(v.exp_miss));
            checkOutput($sformatf("v%0d_aw_beat", idx), 64'(mst_aw.addr), 64'(v.addr));
            checkOutput($sformatf("v%0d_aw_sready", idx), 64'(slv_aw_ready), 64'd0);
`ifdef AXI_ADDR_XLATE_MISS_CNT_EN
            if (v.exp_miss) exp_aw_cnt++;
            checkOutput($sformatf("v%0d_aw_cnt", idx), 64'(aw_miss_cnt), 64'(exp_aw_cnt));
`endif
            mst_aw_ready = 1'b1;
            tick();
            mst_aw_ready = 1'b0;
            checkOutput($sformatf("v%0d_aw_done", idx), 64'(mst_aw_valid), 64'd0);
        end else begin
            checkOutput($sformatf("v%0d_ar_valid", idx), 64'(mst_ar_valid), 64'd1);
            checkOutput($sformatf("v%0d_ar_addr", idx), 64'(mst_ar_addr), 64'(v.exp_addr));
            checkOutput($sformatf("v%0d_ar_miss", idx), 64'(mst_ar_miss), 64'(v.exp_miss));
            checkOutput($sformatf("v%0d_ar_beat", idx), 64'(mst_ar.addr), 64'(v.addr));
            checkOutput($sformatf("v%0d_ar_sready", idx), 64'(slv_ar_ready), 64'd0);
`ifdef AXI_ADDR_XLATE_MISS_CNT_EN
            if (v.exp_miss) exp_ar_cnt++;
            checkOutput($sformatf("v%0d_ar_cnt", idx), 64'(ar_miss_cnt), 64'(exp_ar_cnt));
`endif
            mst_ar_ready = 1'b1;
            tick();
            mst_ar_ready = 1'b0;
            checkOutput($sformatf("v%0d_ar_done", idx), 64'(mst_ar_valid), 64'd0);
        end
    endtask

    initial begin
        // Vector table against the fixed rule set from setTableRules
        vecs[0] = '{1'b0, 32'h0000_1234, 32'h8000_0234, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_1800, 32'h8000_0800, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_1FFF, 32'h8000_0FFF, 1'b0};
        vecs[3] = '{1'b1, 32'h0000_2000, 32'h4000_0800, 1'b0};
        vecs[4] = '{1'b0, 32'h0000_0FFF, 32'h0000_0FFF, 1'b1};
        vecs[5] = '{1'b1, 32'h0000_3000, 32'h0000_3000, 1'b1};
        vecs[6] = '{1'b0, 32'h0000_5000, 32'h0000_5000, 1'b1};
        vecs[7] = '{1'b1, 32'h0000_2FFF, 32'h4000_17FF, 1'b0};

        // Reset state
        tick();
        tick();
        checkOutput("rst_aw_valid", 64'(mst_aw_valid), 64'd0);
        checkOutput("rst_ar_valid", 64'(mst_ar_valid), 64'd0);
        rst = 1'b0;
        checkOutput("rst_aw_ready", 64'(slv_aw_ready), 64'd1);
        checkOutput("rst_ar_ready", 64'(slv_ar_ready), 64'd1);
        checkOutput("rst_aw_addr", 64'(mst_aw_addr), 64'd0);
        checkOutput("rst_aw_miss", 64'(mst_aw_miss), 64'd0);
`ifdef AXI_ADDR_XLATE_MISS_CNT_EN
        checkOutput("rst_aw_cnt", 64'(aw_miss_cnt), 64'd0);
        checkOutput("rst_ar_cnt", 64'(ar_miss_cnt), 64'd0);
`endif

        setTableRules();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(i, vecs[i]);
        end

        // Overlap with rule0 disabled falls through to rule1
        rules[0].en = 1'b0;
        applyStimulus(8, '{1'b0, 32'h0000_1800, 32'h4000_0000, 1'b0});

        // End address is exclusive: only rule0 present, AR at its end misses
        rules    = '0;
        rules[0] = mk_rule(1'b1, 32'h0000_1000, 32'h0000_2000, 32'h8000_0000);
        applyStimulus(9, '{1'b1, 32'h0000_2000, 32'h0000_2000, 1'b1});

        // Downstream stall: outputs frozen while rules and slave input change
        setTableRules();
        slv_aw.addr  = 32'h0000_1234;
        slv_aw.id    = 4'hA;
        slv_aw_valid = 1'b1;
        tick();
        for (int k = 0; k < 10; k++) begin
            rules[0].offset = 32'(k) << 20;
            slv_aw.addr     = 32'h0000_1300 + 32'(k);
            slv_aw.id       = 4'(k);
            tick();
            checkOutput($sformatf("stall%0d_valid", k), 64'(mst_aw_valid), 64'd1);
            checkOutput($sformatf("stall%0d_addr", k), 64'(mst_aw_addr), 64'h8000_0234);
            checkOutput($sformatf("stall%0d_id", k), 64'(mst_aw.id), 64'hA);
            checkOutput($sformatf("stall%0d_sready", k), 64'(slv_aw_ready), 64'd0);
        end
        rules[0].offset = 32'h7000_0000;
        slv_aw.addr     = 32'h0000_1500;
        mst_aw_ready    = 1'b1;
        tick();
        mst_aw_ready = 1'b0;
        checkOutput("stall_release_valid", 64'(mst_aw_valid), 64'd0);
        checkOutput("stall_release_sready", 64'(slv_aw_ready), 64'd1);
        tick();
        slv_aw_valid = 1'b0;
        checkOutput("stall_next_valid", 64'(mst_aw_valid), 64'd1);
        checkOutput("stall_next_addr", 64'(mst_aw_addr), 64'h7000_0500);
        mst_aw_ready = 1'b1;
        tick();
        mst_aw_ready = 1'b0;

        // AW and AR captured together, completed independently
        setTableRules();
        slv_aw.addr  = 32'h0000_1100;
        slv_ar.addr  = 32'h0000_2100;
        slv_aw_valid = 1'b1;
        slv_ar_valid = 1'b1;
        tick();
        slv_aw_valid = 1'b0;
        slv_ar_valid = 1'b0;
        checkOutput("dual_aw_valid", 64'(mst_aw_valid), 64'd1);
        checkOutput("dual_ar_valid", 64'(mst_ar_valid), 64'd1);
        checkOutput("dual_aw_addr", 64'(mst_aw_addr), 64'h8000_0100);
        checkOutput("dual_ar_addr", 64'(mst_ar_addr), 64'h4000_0900);
        mst_ar_ready = 1'b1;
        tick();
        mst_ar_ready = 1'b0;
        checkOutput("dual_ar_done", 64'(mst_ar_valid), 64'd0);
        checkOutput("dual_aw_still", 64'(mst_aw_valid), 64'd1);
        checkOutput("dual_aw_addr_still", 64'(mst_aw_addr), 64'h8000_0100);
        mst_aw_ready = 1'b1;
        tick();
        mst_aw_ready = 1'b0;
        checkOutput("dual_aw_done", 64'(mst_aw_valid), 64'd0);

        // Reset while AW is held drops the beat
        slv_aw.addr  = 32'h0000_0100;
        slv_aw_valid = 1'b1;
        tick();
        slv_aw_valid = 1'b0;
        checkOutput("rsthold_pre_valid", 64'(mst_aw_valid), 64'd1);
        checkOutput("rsthold_pre_miss", 64'(mst_aw_miss), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rsthold_valid", 64'(mst_aw_valid), 64'd0);
        checkOutput("rsthold_sready", 64'(slv_aw_ready), 64'd1);
        checkOutput("rsthold_addr", 64'(mst_aw_addr), 64'd0);
        checkOutput("rsthold_miss", 64'(mst_aw_miss), 64'd0);
`ifdef AXI_ADDR_XLATE_MISS_CNT_EN
        checkOutput("rsthold_aw_cnt", 64'(aw_miss_cnt), 64'd0);
        checkOutput("rsthold_ar_cnt", 64'(ar_miss_cnt), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
